// File: rtl/pipe_stage_reg_pkg.sv
// Shared helpers for the elastic pipeline register: depth limit and counter sizing.
package pipe_stage_reg_pkg;

  localparam int unsigned PSR_MAX_DEPTH = 8;

  // Ceiling log2, usable at elaboration time for port widths.
  function automatic int unsigned psr_clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(val)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned psr_cnt_width(input int unsigned depth);
    return psr_clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One elastic stage: a data word plus its valid bit, reloaded from upstream
// whenever the stage is ready; flush clears the valid bit and leaves data alone.
module pipe_stage_reg_slot #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             flush,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  output logic [WIDTH-1:0] data_q,
  output logic             valid_q,
  output logic             valid_nxt_c
);

  logic [WIDTH-1:0] data_d;
  logic             valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = up_data;
      valid_d = up_valid;
    end
  end

  // Exposed so the parent can keep its occupancy count in step with the valid bits.
  assign valid_nxt_c = valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= RST_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register of DEPTH stages with flush, bubble
// collapsing and a registered occupancy count.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      WIDTH   = 16,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int unsigned     CNT_W   = psr_cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_valid_nxt;
  logic [DEPTH-1:0] stage_rdy;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Ready ripples from the output side back so a full chain still streams.
  always_comb begin
    logic rdy_acc;
    stage_rdy = '0;
    rdy_acc   = !stage_valid[DEPTH-1] || out_ready;
    stage_rdy[DEPTH-1] = rdy_acc;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      rdy_acc      = !stage_valid[i] || rdy_acc;
      stage_rdy[i] = rdy_acc;
    end
  end

  assign in_ready = stage_rdy[0] && !flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      pipe_stage_reg_slot #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_slot (
        .clk         (clk),
        .rst_n       (rst),
        .load        (stage_rdy[i]),
        .flush       (flush),
        .up_data     (in_data),
        .up_valid    (in_valid),
        .data_q      (stage_data[i]),
        .valid_q     (stage_valid[i]),
        .valid_nxt_c (stage_valid_nxt[i])
      );
    end else begin : g_body
      pipe_stage_reg_slot #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_slot (
        .clk         (clk),
        .rst_n       (rst),
        .load        (stage_rdy[i]),
        .flush       (flush),
        .up_data     (stage_data[i-1]),
        .up_valid    (stage_valid[i-1]),
        .data_q      (stage_data[i]),
        .valid_q     (stage_valid[i]),
        .valid_nxt_c (stage_valid_nxt[i])
      );
    end
  end

  // Count tracks the popcount of the valid bits being loaded on this edge.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CNT_W'(stage_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign out_data  = stage_data[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized
// traffic scored against an in-order queue model of the pipeline.
module tb_pipe_stage_reg;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 3;
  localparam logic [15:0] RV = 16'hDEAD;

  logic clk = 1'b0;
  logic rst;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data;
  logic [1:0]  a_count;

  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic b_in_data, b_out_data;
  logic b_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mq[$];
  logic [15:0] got[$];
  logic        last_in_ready;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (a_flush),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .count     (a_count)
  );

  pipe_stage_reg #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b1)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (b_flush),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .count     (b_count)
  );

  // One clock of the DEPTH=3 instance; starts and ends just after a falling edge.
  task automatic cycle_a(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
    logic        exp_rdy, acc, del, hold;
    logic [15:0] held;
    a_in_valid  = iv;
    a_in_data   = id;
    a_out_ready = ordy;
    a_flush     = fl;
    #1;
    exp_rdy = !fl && ((mq.size() < int'(D)) || ordy);
    n_tests++;
    if (a_in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready: got %0b expected %0b (occupancy %0d)", a_in_ready, exp_rdy, mq.size());
    end
    last_in_ready = a_in_ready;
    acc  = iv && exp_rdy;
    del  = a_out_valid && ordy;
    hold = a_out_valid && !ordy && !fl;
    held = a_out_data;
    if (del) begin
      n_tests++;
      if (mq.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_out: got word %h expected no valid word", a_out_data);
      end else if (a_out_data !== mq[0]) begin
        n_fail++;
        $display("FAIL out_order: got %h expected %h", a_out_data, mq[0]);
      end
    end
    @(posedge clk);
    if (del) begin
      got.push_back(held);
      if (mq.size() > 0) void'(mq.pop_front());
    end
    if (fl) mq.delete();
    else if (acc) mq.push_back(id);
    #1;
    n_tests++;
    if (a_count !== 2'(mq.size())) begin
      n_fail++;
      $display("FAIL count: got %0d expected %0d", a_count, mq.size());
    end
    if (hold) begin
      n_tests++;
      if (a_out_valid !== 1'b1 || a_out_data !== held) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%0b d=%h expected v=1 d=%h", a_out_valid, a_out_data, held);
      end
    end
    if (mq.size() == 0) begin
      n_tests++;
      if (a_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_valid: got %0b expected 0", a_out_valid);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (4) begin
      a_in_valid = 1'($urandom); a_in_data = 16'($urandom); a_out_ready = 1'($urandom); a_flush = 1'b0;
      b_in_valid = 1'($urandom); b_in_data = 1'($urandom); b_out_ready = 1'($urandom); b_flush = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (a_out_valid !== 1'b0 || a_out_data !== RV || a_count !== 2'd0 || a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_a: got v=%0b d=%h c=%0d r=%0b expected v=0 d=dead c=0 r=1",
                 a_out_valid, a_out_data, a_count, a_in_ready);
      end
      n_tests++;
      if (b_out_valid !== 1'b0 || b_out_data !== 1'b1 || b_count !== 1'b0 || b_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_b: got v=%0b d=%0b c=%0d r=%0b expected v=0 d=1 c=0 r=1",
                 b_out_valid, b_out_data, b_count, b_in_ready);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    mq.delete();
    got.delete();
  endtask

  task automatic test_streaming();
    logic exp_v;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 4) cycle_a(1'b1, 16'(k), 1'b1, 1'b0);
      else        cycle_a(1'b0, 16'h0, 1'b1, 1'b0);
      exp_v = (k >= 3) && (k <= 6);
      n_tests++;
      if (a_out_valid !== exp_v || (exp_v && a_out_data !== 16'(k - 2))) begin
        n_fail++;
        $display("FAIL stream_k%0d: got v=%0b d=%h expected v=%0b d=%h",
                 k, a_out_valid, a_out_data, exp_v, 16'(k - 2));
      end
      if (k == 3 || k == 4) begin
        n_tests++;
        if (a_count !== 2'd3) begin
          n_fail++;
          $display("FAIL stream_count: got %0d expected 3", a_count);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    got.delete();
    for (int k = 0; k < 3; k++) cycle_a(1'b1, 16'(5 + k), 1'b0, 1'b0);
    n_tests++;
    if (a_count !== 2'd3 || a_out_valid !== 1'b1 || a_out_data !== 16'd5) begin
      n_fail++;
      $display("FAIL bp_full: got c=%0d v=%0b d=%h expected c=3 v=1 d=0005", a_count, a_out_valid, a_out_data);
    end
    cycle_a(1'b1, 16'd8, 1'b0, 1'b0);
    n_tests++;
    if (last_in_ready !== 1'b0 || a_out_data !== 16'd5) begin
      n_fail++;
      $display("FAIL bp_block: got r=%0b d=%h expected r=0 d=0005", last_in_ready, a_out_data);
    end
    cycle_a(1'b1, 16'd8, 1'b1, 1'b0);
    n_tests++;
    if (last_in_ready !== 1'b1 || a_out_data !== 16'd6 || a_count !== 2'd3) begin
      n_fail++;
      $display("FAIL bp_pass: got r=%0b d=%h c=%0d expected r=1 d=0006 c=3", last_in_ready, a_out_data, a_count);
    end
    repeat (3) cycle_a(1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL bp_drain_len: got %0d words expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (got[i] !== 16'(5 + i)) begin
          n_fail++;
          $display("FAIL bp_drain_%0d: got %h expected %h", i, got[i], 16'(5 + i));
        end
      end
    end
  endtask

  task automatic test_bubble();
    logic [15:0] wa, wb;
    wa = 16'($urandom);
    wb = 16'($urandom);
    cycle_a(1'b1, wa, 1'b0, 1'b0);
    repeat (2) cycle_a(1'b0, 16'h0, 1'b0, 1'b0);
    cycle_a(1'b1, wb, 1'b0, 1'b0);
    repeat (2) cycle_a(1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (a_count !== 2'd2 || a_out_data !== wa) begin
      n_fail++;
      $display("FAIL bubble_pack: got c=%0d d=%h expected c=2 d=%h", a_count, a_out_data, wa);
    end
    got.delete();
    cycle_a(1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_data !== wb) begin
      n_fail++;
      $display("FAIL bubble_b2b: got v=%0b d=%h expected v=1 d=%h", a_out_valid, a_out_data, wb);
    end
    cycle_a(1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (got.size() != 2 || a_count !== 2'd0) begin
      n_fail++;
      $display("FAIL bubble_drain: got %0d words c=%0d expected 2 words c=0", got.size(), a_count);
    end
  endtask

  task automatic test_flush();
    repeat (3) cycle_a(1'b1, 16'($urandom), 1'b0, 1'b0);
    cycle_a(1'b1, 16'hBEEF, 1'b0, 1'b1);
    n_tests++;
    if (last_in_ready !== 1'b0 || a_count !== 2'd0 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: got r=%0b c=%0d v=%0b expected r=0 c=0 v=0", last_in_ready, a_count, a_out_valid);
    end
    got.delete();
    repeat (5) cycle_a(1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (got.size() != 0) begin
      n_fail++;
      $display("FAIL flush_leak: got %0d words expected 0", got.size());
    end
  endtask

  task automatic test_async_reset();
    repeat (3) cycle_a(1'b1, 16'($urandom), 1'b0, 1'b0);
    n_tests++;
    if (a_count !== 2'd3) begin
      n_fail++;
      $display("FAIL areset_prefill: got c=%0d expected 3", a_count);
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0 || a_count !== 2'd0 || a_out_data !== RV || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset: got v=%0b c=%0d d=%h r=%0b expected v=0 c=0 d=dead r=1",
               a_out_valid, a_count, a_out_data, a_in_ready);
    end
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic iv, ordy, fl;
    for (int n = 0; n < 1500; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      cycle_a(iv, 16'($urandom), ordy, fl);
    end
    repeat (6) cycle_a(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic test_depth1();
    logic w;
    for (int k = 0; k < 4; k++) begin
      w = 1'($urandom);
      b_in_valid = 1'b1; b_in_data = w; b_out_ready = 1'b1; b_flush = 1'b0;
      #1;
      n_tests++;
      if (b_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL d1_ready_%0d: got %0b expected 1", k, b_in_ready);
      end
      @(posedge clk); #1;
      n_tests++;
      if (b_out_valid !== 1'b1 || b_out_data !== w || b_count !== 1'b1) begin
        n_fail++;
        $display("FAIL d1_stream_%0d: got v=%0b d=%0b c=%0d expected v=1 d=%0b c=1",
                 k, b_out_valid, b_out_data, b_count, w);
      end
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (b_out_valid !== 1'b0 || b_count !== 1'b0) begin
      n_fail++;
      $display("FAIL d1_drain: got v=%0b c=%0d expected v=0 c=0", b_out_valid, b_count);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 16'h0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 1'b0; b_out_ready = 1'b0;
    last_in_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    test_depth1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
